// File: rtl/mul_seq_if.sv
// Handshake and data bundle for the iterative multiplier.
// The master side supplies operands and accepts the product; the slave side is the multiplier.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   a_signed;
    logic                   b_signed;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     C;

    modport master (
        output in_valid, a_signed, b_signed, A, B, out_ready,
        input  in_ready, out_valid, C
    );

    modport slave (
        input  in_valid, a_signed, b_signed, A, B, out_ready,
        output in_ready, out_valid, C
    );
endinterface

// File: rtl/mul_seq.sv
// Multi-cycle iterative multiplier producing a full 2*WIDTH product.
// Operands are reduced to unsigned magnitudes on acceptance, STEP bits of |B| are
// consumed per cycle (LSB first), and the sign is applied once on the final iteration.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
`ifdef USE_POWER_PINS
    inout wire        VPWR,
    inout wire        VGND,
`endif
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);

    localparam int N     = WIDTH / STEP;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P    = PW'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject illegal parameterisations at elaboration time.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("mul_seq: WIDTH must be at least 2");
        end
        if (STEP < 1) begin : g_bad_step
            $error("mul_seq: STEP must be positive");
        end else if ((WIDTH % STEP) != 0) begin : g_bad_div
            $error("mul_seq: STEP must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     a_sh_q, a_sh_d;   // |A| pre-shifted to the weight of the current digit
    logic [WIDTH-1:0]  b_q, b_d;         // remaining digits of |B|, current digit in the LSBs
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     c_q, c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic              in_ready_c;
    logic              out_valid_c;

    // Operand conditioning: the most negative value negates to itself, which reads
    // correctly as an unsigned magnitude of 2^(WIDTH-1).
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;

    assign a_neg = bus.a_signed & bus.A[WIDTH-1];
    assign b_neg = bus.b_signed & bus.B[WIDTH-1];
    assign a_mag = a_neg ? ((~bus.A) + ONE_W) : bus.A;
    assign b_mag = b_neg ? ((~bus.B) + ONE_W) : bus.B;

    // One shifted copy of |A| per bit of the current digit.
    logic [PW-1:0] pp_term [STEP];

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp_term[gi] = b_q[gi] ? (a_sh_q << gi) : '0;
        end
    endgenerate

    logic [PW-1:0] partial;
    logic [PW-1:0] acc_sum;

    // Sum the selected copies into this iteration's partial product.
    always_comb begin
        partial = '0;
        for (int k = 0; k < STEP; k++) begin
            partial = partial + pp_term[k];
        end
        acc_sum = acc_q + partial;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_d         = b_q;
        acc_d       = acc_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    a_sh_d  = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                acc_d  = acc_sum;
                a_sh_d = a_sh_q << STEP;
                b_d    = b_q >> STEP;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    c_d     = neg_q ? ((~acc_sum) + ONE_P) : acc_sum;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.C         = c_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, randomized operations
// against a wide-arithmetic reference product, backpressure, reset abort and back-to-back use.
module tb_mul_seq;

    localparam int W   = 32;
    localparam int STP = 4;
    localparam int NIT = W / STP;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_seq_if #(.WIDTH(W)) bus ();

    mul_seq #(.WIDTH(W), .STEP(STP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product: sign- or zero-extend both operands far beyond the product
    // width, multiply, keep the low 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input bit as, input bit bs);
        logic signed [4*W-1:0] ea, eb, p;
        ea = as ? {{(3*W){a[W-1]}}, a} : {{(3*W){1'b0}}, a};
        eb = bs ? {{(3*W){b[W-1]}}, b} : {{(3*W){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    // Issue one operation (called #1 after a rising edge while idle), wait for the
    // result with a cycle bound, and optionally complete the output handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit as, input bit bs,
                         input bit release_out,
                         output logic [2*W-1:0] c, output int lat, output bit ready_ok);
        bus.A        = a;
        bus.B        = b;
        bus.a_signed = as;
        bus.b_signed = bs;
        bus.in_valid = 1'b1;
        ready_ok     = (bus.in_ready === 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        bus.a_signed = 1'($urandom);
        bus.b_signed = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        c = bus.C;
        $display("op A=%h B=%h as=%0d bs=%0d -> C=%h lat=%0d", a, b, as, bs, c, lat);
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.a_signed  = 1'b0;
        bus.b_signed  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.C !== '0) begin
            errors++;
            $display("FAIL reset_C got=%h want=0", bus.C);
        end
        $display("reset released in_ready=%b out_valid=%b C=%h", bus.in_ready, bus.out_valid, bus.C);
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [7] = '{32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                   32'h80000000, 32'hFFFFFFFF, 32'h200};
        logic [W-1:0]   tb [7] = '{32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                   32'h2, 32'hFFFFFFFF, 32'h2000};
        bit             tas [7] = '{0, 0, 1, 1, 1, 1, 0};
        bit             tbs [7] = '{0, 0, 1, 1, 0, 0, 0};
        logic [2*W-1:0] te [7] = '{64'h0000000000000020, 64'hFFFFFFFE00000001,
                                   64'h0000000000000001, 64'h4000000000000000,
                                   64'hFFFFFFFF00000000, 64'hFFFFFFFF00000001,
                                   64'h0000000000400000};
        logic [2*W-1:0] c;
        int             lat;
        bit             rok;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], tas[i], tbs[i], 1'b1, c, lat, rok);
            checks++;
            if (c !== te[i]) begin
                errors++;
                $display("FAIL directed_C[%0d] got=%h want=%h", i, c, te[i]);
            end
            checks++;
            if (lat != NIT) begin
                errors++;
                $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, NIT);
            end
            checks++;
            if (!rok) begin
                errors++;
                $display("FAIL directed_in_ready[%0d] got=busy-high want=low-while-busy", i);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        bit             as, bs;
        logic [2*W-1:0] c, e;
        int             lat;
        bit             rok;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: a = '0;
                1: b = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                default: ;
            endcase
            as = 1'($urandom);
            bs = 1'($urandom);
            e  = ref_mul(a, b, as, bs);
            do_op(a, b, as, bs, 1'b1, c, lat, rok);
            checks++;
            if (c !== e) begin
                errors++;
                $display("FAIL random_C[%0d] got=%h want=%h", i, c, e);
            end
            checks++;
            if (lat != NIT || !rok) begin
                errors++;
                $display("FAIL random_timing[%0d] got lat=%0d ready_ok=%0d want lat=%0d ready_ok=1",
                         i, lat, rok, NIT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] c, e, e2;
        int             lat;
        bit             rok;
        e = ref_mul(32'd123456, 32'hFFFFFFFB, 1'b0, 1'b1);
        do_op(32'd123456, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, c, lat, rok);
        checks++;
        if (c !== e) begin
            errors++;
            $display("FAIL bp_C got=%h want=%h", c, e);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.A        = 32'd99;
            bus.B        = 32'd77;
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.C !== e || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got valid=%b ready=%b C=%h want valid=1 ready=0 C=%h",
                         i, bus.out_valid, bus.in_ready, bus.C, e);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.C !== e) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b C=%h want valid=0 ready=1 C=%h",
                     bus.out_valid, bus.in_ready, bus.C, e);
        end
        $display("backpressure released C=%h", bus.C);
        e2 = ref_mul(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, c, lat, rok);
        checks++;
        if (c !== e2 || lat != NIT) begin
            errors++;
            $display("FAIL bp_next_op got C=%h lat=%0d want C=%h lat=%0d", c, lat, e2, NIT);
        end
    endtask

    task automatic test_reset_abort();
        logic [2*W-1:0] c;
        int             lat;
        bit             rok;
        bus.A        = 32'h12345678;
        bus.B        = 32'h9ABCDEF0;
        bus.a_signed = 1'b1;
        bus.b_signed = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.C !== '0) begin
            errors++;
            $display("FAIL abort_state got ready=%b valid=%b C=%h want ready=1 valid=0 C=0",
                     bus.in_ready, bus.out_valid, bus.C);
        end
        $display("reset abort in_ready=%b out_valid=%b C=%h", bus.in_ready, bus.out_valid, bus.C);
        do_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b1, c, lat, rok);
        checks++;
        if (c !== 64'd42) begin
            errors++;
            $display("FAIL abort_next_C got=%h want=%h", c, 64'd42);
        end
        checks++;
        if (lat != NIT || !rok) begin
            errors++;
            $display("FAIL abort_next_latency got=%0d want=%0d", lat, NIT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a, b;
        bit             as, bs;
        logic [2*W-1:0] c, e;
        int             lat;
        bit             rok;
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = $urandom;
            as = 1'($urandom);
            bs = 1'($urandom);
            e  = ref_mul(a, b, as, bs);
            do_op(a, b, as, bs, 1'b1, c, lat, rok);
            checks++;
            if (c !== e || lat != NIT || !rok) begin
                errors++;
                $display("FAIL b2b[%0d] got C=%h lat=%0d ready_ok=%0d want C=%h lat=%0d ready_ok=1",
                         i, c, lat, rok, e, NIT);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Parametrised, multi-cycle iterative multiplier; successor to the fixed 32x32 combinational-style multiplier.
- Computes a full-width 2*WIDTH product and processes STEP bits of B per cycle.
- Supports signed or unsigned treatment of each operand, chosen per operation.
- Uses valid/ready handshakes on input and output so it can sit between pipeline stages in the datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 2.
- STEP, 4, bits of B consumed per iteration. Must divide WIDTH exactly; elaboration fails otherwise.
- Derived: N = WIDTH/STEP, the number of iterations.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation
- a_signed  input  1  1 = treat A as two's complement
- b_signed  input  1  1 = treat B as two's complement
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- out_valid  output  1  C holds a completed product
- out_ready  input  1  consumer accepts C
- C  output  2*WIDTH  product, two's complement when either operand is signed
- VPWR, VGND  inout  1  power pins, present only under USE_POWER_PINS

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and takes priority over every other input.
- Values on reset:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - C = 0
  - all internal accumulator, operand and counter registers = 0
- State machine, IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: in_ready = 1. On a clock edge with in_valid = 1:
    - latch |A| and |B| as WIDTH-bit unsigned magnitudes. A negative signed operand is negated; the most negative value 2^(WIDTH-1) is kept as an unsigned magnitude.
    - latch neg = (a_signed & A[MSB]) ^ (b_signed & B[MSB]).
    - clear the accumulator and the iteration counter.
    - go to BUSY.
  - BUSY: in_ready = 0. Each edge:
    - acc += |A| * (next STEP bits of |B|, LSB first), shifted to the correct position.
    - count += 1.
    - On the Nth BUSY edge, register C = neg ? -acc_final : acc_final (modulo 2^(2*WIDTH)), set out_valid = 1 and go to DONE.
  - DONE: out_valid = 1 and C is stable. On an edge with out_ready = 1: out_valid = 0, go to IDLE.
- Latency: out_valid rises exactly N cycles after the acceptance edge (8 cycles with defaults).
- Throughput: at best one operation per N+2 cycles. in_ready is asserted only in IDLE, so there is no overlap of operations.
- Backpressure: out_ready = 0 holds DONE indefinitely, with C and out_valid unchanged.
- C keeps its last value after the output handshake until the next result is written. out_valid is the only qualifier of C.
- in_valid is ignored outside IDLE. Operands need to be held only on the acceptance edge.
- Reset during BUSY or DONE aborts the operation: the result is discarded and the reset values above apply on the next cycle.
- Result range: every signed/unsigned combination fits in 2*WIDTH bits without overflow.
  - Worst signed case: (-2^(W-1))^2 = 2^(2W-2).
  - Worst mixed case: magnitude 2^(W-1)*(2^W-1) < 2^(2W-1).
- Zero operands follow the normal iteration count; there is no early termination.

Test Plan:
1. Unsigned, A=0x10, B=0x2 -> C=0x0000000000000020; out_valid rises exactly 8 cycles after acceptance; in_ready = 0 throughout.
2. Unsigned, A=B=0xFFFFFFFF -> C=0xFFFFFFFE00000001. Signed, A=B=0xFFFFFFFF (-1*-1) -> C=0x0000000000000001.
3. Signed, A=B=0x80000000 -> C=0x4000000000000000. Signed A=0x80000000 with unsigned B=0x00000002 -> C=0xFFFFFFFF00000000.
4. Mixed mode, a_signed=1 with A=0xFFFFFFFF, b_signed=0 with B=0xFFFFFFFF -> C=0xFFFFFFFF00000001. Unsigned A=0x200, B=0x2000 -> C=0x0000000000400000.
5. Backpressure and ignored input:
   - Hold out_ready = 0 for 5 cycles after out_valid rises -> C and out_valid remain stable.
   - Drive new in_valid during DONE -> it is ignored.
   - Raise out_ready -> out_valid falls, in_ready = 1 on the next cycle, and the new operation is accepted correctly.
6. Assert rst for 1 cycle at BUSY iteration 3 -> next cycle in_ready = 1, out_valid = 0, C = 0; a following 7*6 operation gives C=42 with full latency.
